fetch_seq: RTL and testbench
============================

# fetch_seq

Instruction fetch sequencer for the 16-bit accumulator machine (12-bit address space, 4K x 16 memory). Owns the program counter, drives the memory block's `read` strobe and address, captures each instruction word, resolves the indirect bit for memory-reference instructions, and hands a decoded instruction to the execute stage over a valid/ready handshake. It sits directly upstream of the memory block on the read side and never drives its `write` strobe.

## Interface
- `RESET_PC`, default 12'h000: PC value loaded by reset.
- `clk` input 1: clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `halt` input 1: when high, no new fetch is started.
- `redir_valid` input 1: PC redirect (BUN/BSA/ISZ skip) from execute.
- `redir_pc` input 12: redirect target.
- `mem_read` output 1: connects to memory `read`; registered one-cycle pulse per access.
- `mem_addr` output 12: connects to memory `i`; registered.
- `mem_rdata` input 16: connects to memory `memout`.
- `instr_valid` output 1: decoded instruction available.
- `instr_ready` input 1: execute accepts the instruction.
- `instr_ir` output 16: raw instruction word.
- `instr_ea` output 12: effective address.
- `instr_cls` output 2: 00 memory-reference, 01 register-reference (opcode 7, I=0), 10 I/O (opcode 7, I=1).
- `instr_pc` output 12: PC after increment (address of next instruction).

## Operation
- States: IDLE, F_RD, F_WT, DEC, I_RD, I_WT, ISSUE.
- IDLE: if `!halt`, go to F_RD.
- F_RD: `mem_read`=1, `mem_addr`=PC → F_WT.
- F_WT: `mem_read`=0; at the end of the cycle, IR <= `mem_rdata`, PC <= PC+1 (12-bit, 12'hFFF wraps to 12'h000) → DEC.
- DEC: classify IR[15:12]. Memory-reference with IR[15]=1 → I_RD with `mem_addr`=IR[11:0]; otherwise EA <= IR[11:0] → ISSUE.
- I_RD: `mem_read`=1 → I_WT. I_WT: EA <= `mem_rdata[11:0]` → ISSUE.
- ISSUE: `instr_valid`=1. Outputs are held stable until `instr_ready`. On handshake → F_RD, or IDLE if `halt`.
- Register-reference and I/O instructions: EA = IR[11:0] and no indirect read, even though IR[15] is 1 for I/O.
- Redirect (`redir_valid`): in any state, PC <= `redir_pc`, any in-flight fetch is abandoned, `instr_valid` drops the next cycle, state → F_RD (IDLE if `halt`). If it arrives in ISSUE together with `instr_ready`, the handshake completes and the redirect PC is still used.
- `halt` is sampled only at IDLE/ISSUE exits; an in-flight fetch completes to ISSUE.
- `reset` wins over everything.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `mem_read`=0, `mem_addr`=0, `instr_valid`=0, `instr_ir`=0, `instr_ea`=0, `instr_cls`=0, `instr_pc`=0.
- `mem_read` is never high in two consecutive cycles, so every access produces a fresh rising edge.
- Direct fetch: F_RD entered at cycle n gives `instr_valid`=1 at cycle n+3. An indirect fetch adds 2 cycles (n+5).
- Back-to-back throughput with `instr_ready` held high: one direct instruction per 4 cycles.
- `mem_rdata` is sampled only at the end of F_WT and I_WT.

## Configuration
- `FETCH_INDIRECT_EN` defined: indirect resolution as above (I_RD/I_WT used).
- Not defined: I_RD/I_WT are removed. DEC always goes to ISSUE with EA = IR[11:0]. Execute performs the indirection, using IR[15] as the flag.

## Structure
- Shared package `mano_pkg`: state enum, `instr_cls` encodings, opcode constant 3'b111 (register/IO group), address/word width constants (12, 16).
- One combinational sub-module `instr_classify` (IR in → `instr_cls` out, plus a needs-indirect flag). The FSM, PC, IR and EA live in `fetch_seq`.

## Test plan
- Reset with `RESET_PC`=0, memory[0]=16'h7020, `instr_ready`=1 → `mem_read` pulse at addr 0; at cycle 3, `instr_valid`=1, ir=7020, cls=01, ea=020, pc=001.
- Indirect: mem[0]=16'h90AA, mem[0AA]=16'h0123 → second read at addr 0AA; issue ea=123, cls=00, 5 cycles after F_RD. Without `FETCH_INDIRECT_EN`: ea=0AA, 3 cycles.
- I/O word mem[0]=16'hF400 → cls=10, ea=400, no indirect read.
- Backpressure: `instr_ready`=0 for 6 cycles → outputs stable, no `mem_read`; release → next fetch at addr pc.
- Redirect `redir_pc`=12'h005 asserted during F_WT → fetched word discarded; next `mem_read` at addr 005.
- Wrap: `RESET_PC`=12'hFFF → `instr_pc`=000; `halt`=1 during ISSUE → after handshake, state IDLE with no further reads.

Source files
------------

// File: rtl/mano_pkg.sv
// -----------------------------------------------------------------------------
// mano_pkg
// Shared definitions for the 16-bit accumulator machine front end:
//   - address / word widths (12-bit address, 16-bit word)
//   - fetch sequencer state encodings
//   - instr_cls encodings and the register/IO opcode group constant
//   - is_reg_io_grp(): helper that recognises the opcode-7 group
// Optional feature macro used by the importing files: FETCH_INDIRECT_EN.
// -----------------------------------------------------------------------------
package mano_pkg;

   localparam int ADDR_W = 12;
   localparam int WORD_W = 16;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_F_RD  = 3'd1;
   localparam state_t S_F_WT  = 3'd2;
   localparam state_t S_DEC   = 3'd3;
   localparam state_t S_I_RD  = 3'd4;
   localparam state_t S_I_WT  = 3'd5;
   localparam state_t S_ISSUE = 3'd6;

   localparam logic [1:0] CLS_MEM = 2'b00;
   localparam logic [1:0] CLS_REG = 2'b01;
   localparam logic [1:0] CLS_IO  = 2'b10;

   localparam logic [2:0] OPC_REG_IO = 3'b111;

   // True when the 3-bit opcode field selects the register/IO group.
   function automatic logic is_reg_io_grp(input logic [2:0] opc);
      return (opc == OPC_REG_IO);
   endfunction

endpackage

// File: rtl/instr_classify.sv
// -----------------------------------------------------------------------------
// instr_classify
// Combinational classification of an instruction word's top nibble.
// Ports:
//   op_i        [3:0] : IR[15:12] (I bit + opcode)
//   cls_o       [1:0] : 00 memory-reference, 01 register-reference, 10 I/O
//   needs_ind_o       : memory-reference with I=1 (only when FETCH_INDIRECT_EN
//                       is defined; otherwise execute handles indirection)
// -----------------------------------------------------------------------------
module instr_classify
   import mano_pkg::*;
(
   input  logic [3:0] op_i,
   output logic [1:0] cls_o
`ifdef FETCH_INDIRECT_EN
   ,
   output logic       needs_ind_o
`endif
);

   logic grp_s;

   // Decode the class; the I bit distinguishes register-ref from I/O in group 7.
   always_comb begin
      grp_s = is_reg_io_grp(op_i[2:0]);
      if (grp_s) begin
         if (op_i[3]) begin
            cls_o = CLS_IO;
         end else begin
            cls_o = CLS_REG;
         end
      end else begin
         cls_o = CLS_MEM;
      end
`ifdef FETCH_INDIRECT_EN
      // I/O words carry I=1 too, so the indirect flag is masked by the group.
      needs_ind_o = (!grp_s) && op_i[3];
`endif
   end

endmodule

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
// Instruction fetch sequencer: owns the PC, issues single-cycle read pulses to
// the memory block, captures IR, optionally resolves the indirect bit, and
// presents a decoded instruction to execute over valid/ready.
// Optional feature macro: FETCH_INDIRECT_EN (enables the I_RD/I_WT states).
// Parameters:
//   RESET_PC           : PC loaded by reset
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   halt               : blocks starting a new fetch (sampled at IDLE/ISSUE exits)
//   redir_valid/pc     : PC redirect from execute, abandons in-flight work
//   mem_read/addr      : registered read strobe and address to memory
//   mem_rdata          : memory read data
//   instr_valid/ready  : issue handshake
//   instr_ir/ea/cls/pc : issued word, effective address, class, PC+1
// -----------------------------------------------------------------------------
module fetch_seq
   import mano_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [WORD_W-1:0] instr_ir,
   output logic [ADDR_W-1:0] instr_ea,
   output logic [1:0]        instr_cls,
   output logic [ADDR_W-1:0] instr_pc
);

   state_t              state_q, state_d, seq_state_s;
   logic [ADDR_W-1:0]   pc_q, pc_d, seq_pc_s;
   logic [WORD_W-1:0]   ir_q, ir_d;
   logic                mem_read_q, mem_read_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                valid_q, valid_d;
   logic [WORD_W-1:0]   out_ir_q, out_ir_d;
   logic [ADDR_W-1:0]   out_ea_q, out_ea_d;
   logic [1:0]          out_cls_q, out_cls_d;
   logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
   logic [ADDR_W-1:0]   ea_src_s;
   logic [1:0]          cls_s;
`ifdef FETCH_INDIRECT_EN
   logic                needs_ind_s;
`endif

   instr_classify u_classify (
      .op_i        (ir_q[WORD_W-1:WORD_W-4]),
      .cls_o       (cls_s)
`ifdef FETCH_INDIRECT_EN
      ,
      .needs_ind_o (needs_ind_s)
`endif
   );

   // Next-state, PC/IR update, read launch and issue-register load.
   always_comb begin
      seq_state_s = state_q;
      seq_pc_s    = pc_q;
      ir_d        = ir_q;
      ea_src_s    = ir_q[ADDR_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (!halt) begin
               seq_state_s = S_F_RD;
            end else begin
               seq_state_s = S_IDLE;
            end
         end
         S_F_RD: begin
            // A redirect that lands while a read pulse is out re-enters F_RD
            // with the strobe low; the pulse is then launched one cycle later
            // so the strobe never stays high across two cycles.
            if (mem_read_q) begin
               seq_state_s = S_F_WT;
            end else begin
               seq_state_s = S_F_RD;
            end
         end
         S_F_WT: begin
            ir_d        = mem_rdata;
            seq_pc_s    = pc_q + 12'd1;
            seq_state_s = S_DEC;
         end
         S_DEC: begin
`ifdef FETCH_INDIRECT_EN
            if (needs_ind_s) begin
               seq_state_s = S_I_RD;
            end else begin
               seq_state_s = S_ISSUE;
            end
`else
            seq_state_s = S_ISSUE;
`endif
         end
`ifdef FETCH_INDIRECT_EN
         S_I_RD: begin
            seq_state_s = S_I_WT;
         end
         S_I_WT: begin
            ea_src_s    = mem_rdata[ADDR_W-1:0];
            seq_state_s = S_ISSUE;
         end
`endif
         S_ISSUE: begin
            if (instr_ready) begin
               if (halt) begin
                  seq_state_s = S_IDLE;
               end else begin
                  seq_state_s = S_F_RD;
               end
            end else begin
               seq_state_s = S_ISSUE;
            end
         end
         default: begin
            seq_state_s = S_IDLE;
         end
      endcase

      // Redirect overrides whatever the sequence wanted, including a handshake.
      if (redir_valid) begin
         pc_d = redir_pc;
         if (halt) begin
            state_d = S_IDLE;
         end else begin
            state_d = S_F_RD;
         end
      end else begin
         pc_d    = seq_pc_s;
         state_d = seq_state_s;
      end

      if ((state_d == S_F_RD) || (state_d == S_I_RD)) begin
         mem_read_d = !mem_read_q;
      end else begin
         mem_read_d = 1'b0;
      end

      if (state_d == S_F_RD) begin
         mem_addr_d = pc_d;
      end else if (state_d == S_I_RD) begin
         mem_addr_d = ir_q[ADDR_W-1:0];
      end else begin
         mem_addr_d = mem_addr_q;
      end

      valid_d = (state_d == S_ISSUE);

      // Issue registers load only on entry to ISSUE and hold during backpressure.
      if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
         out_ir_d  = ir_q;
         out_ea_d  = ea_src_s;
         out_cls_d = cls_s;
         out_pc_d  = pc_q;
      end else begin
         out_ir_d  = out_ir_q;
         out_ea_d  = out_ea_q;
         out_cls_d = out_cls_q;
         out_pc_d  = out_pc_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 16'h0000;
         mem_read_q <= 1'b0;
         mem_addr_q <= 12'h000;
         valid_q    <= 1'b0;
         out_ir_q   <= 16'h0000;
         out_ea_q   <= 12'h000;
         out_cls_q  <= 2'b00;
         out_pc_q   <= 12'h000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         mem_read_q <= mem_read_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
         out_ir_q   <= out_ir_d;
         out_ea_q   <= out_ea_d;
         out_cls_q  <= out_cls_d;
         out_pc_q   <= out_pc_d;
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_addr    = mem_addr_q;
   assign instr_valid = valid_q;
   assign instr_ir    = out_ir_q;
   assign instr_ea    = out_ea_q;
   assign instr_cls   = out_cls_q;
   assign instr_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
// Self-checking bench for fetch_seq: directed scenarios followed by a run over
// random memory contents, checked against a transaction-level fetch model.
// Follows the FETCH_INDIRECT_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

`ifdef FETCH_INDIRECT_EN
   localparam bit IND = 1'b1;
`else
   localparam bit IND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, halt, redir_valid, instr_ready;
   logic [11:0] redir_pc;
   logic        mem_read;
   logic [11:0] mem_addr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        instr_valid;
   logic [15:0] instr_ir;
   logic [11:0] instr_ea;
   logic [1:0]  instr_cls;
   logic [11:0] instr_pc;

   logic [15:0] mem [0:4095];
   logic [11:0] rd_q [$];
   logic        prev_read = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   fetch_seq #(.RESET_PC(12'h000)) dut (
      .clk(clk), .reset(reset), .halt(halt),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_ir(instr_ir), .instr_ea(instr_ea), .instr_cls(instr_cls),
      .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // Memory block: a read strobe at an edge presents the word for the next cycle.
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample just after the edge, log reads and check strobe gaps.
   task automatic tick();
      @(posedge clk);
      #1;
      if (mem_read) begin
         chk("read_back_to_back", {31'd0, prev_read}, 32'd0);
         rd_q.push_back(mem_addr);
      end
      prev_read = mem_read;
   endtask

   // Expected result of fetching at address a, from the instruction-set rules.
   task automatic model(input logic [11:0] a, output logic [15:0] w, output logic [11:0] ea,
                        output logic [1:0] cls, output bit ind);
      w   = mem[a];
      ind = 1'b0;
      if (w[14:12] == 3'b111) begin
         cls = w[15] ? 2'b10 : 2'b01;
         ea  = w[11:0];
      end else begin
         cls = 2'b00;
         ind = IND && w[15];
         ea  = ind ? mem[w[11:0]][11:0] : w[11:0];
      end
   endtask

   // Wait (bounded) for instr_valid after a fetch read was seen; check latency and fields.
   task automatic exp_issue(input string tag, input logic [15:0] ir, input logic [11:0] ea,
                            input logic [1:0] cls, input logic [11:0] pc, input int lat_exp);
      int lat = 0;
      while (!instr_valid && lat < 12) begin
         tick();
         lat++;
      end
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_lat"}, lat, lat_exp);
      chk({tag, "_ir"}, {16'd0, instr_ir}, {16'd0, ir});
      chk({tag, "_ea"}, {20'd0, instr_ea}, {20'd0, ea});
      chk({tag, "_cls"}, {30'd0, instr_cls}, {30'd0, cls});
      chk({tag, "_pc"}, {20'd0, instr_pc}, {20'd0, pc});
   endtask

   // Start a fetch at addr from IDLE via a redirect.
   task automatic fetch_at(input logic [11:0] addr);
      rd_q.delete();
      halt        = 1'b0;
      redir_valid = 1'b1;
      redir_pc    = addr;
      tick();
      redir_valid = 1'b0;
      chk("fetch_rd", {31'd0, mem_read}, 32'd1);
      chk("fetch_addr", {20'd0, mem_addr}, {20'd0, addr});
   endtask

   // Accept the issued instruction with halt high; the sequencer must go quiet.
   task automatic retire_halt();
      int n;
      halt        = 1'b1;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("halt_valid_drop", {31'd0, instr_valid}, 32'd0);
      n = rd_q.size();
      repeat (3) tick();
      chk("halt_no_reads", rd_q.size(), n);
   endtask

   initial begin : main
      logic [15:0] w;
      logic [11:0] ea, pc;
      logic [1:0]  cls;
      bit          ind;
      int          n;

      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      mem[12'h000] = 16'h7020;
      mem[12'h001] = 16'h1234;
      mem[12'h002] = 16'hF400;

      // Reset state with instr_ready high
      reset = 1'b1; halt = 1'b0; redir_valid = 1'b0; redir_pc = 12'h000; instr_ready = 1'b1;
      tick(); tick();
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_ir", {16'd0, instr_ir}, 32'd0);
      chk("rst_ea", {20'd0, instr_ea}, 32'd0);
      chk("rst_cls", {30'd0, instr_cls}, 32'd0);
      chk("rst_pc", {20'd0, instr_pc}, 32'd0);
      reset = 1'b0;
      rd_q.delete();

      // First fetch from RESET_PC: register-reference word
      tick();
      chk("rr_rd", {31'd0, mem_read}, 32'd1);
      chk("rr_addr", {20'd0, mem_addr}, 32'd0);
      exp_issue("rr", 16'h7020, 12'h020, 2'b01, 12'h001, 3);

      // Handshake with ready high: next fetch starts right away (4-cycle rate)
      tick();
      chk("b2b_rd", {31'd0, mem_read}, 32'd1);
      chk("b2b_addr", {20'd0, mem_addr}, 32'h001);
      chk("b2b_valid", {31'd0, instr_valid}, 32'd0);
      instr_ready = 1'b0;
      exp_issue("mr", 16'h1234, 12'h234, 2'b00, 12'h002, 3);

      // Backpressure: outputs hold, no reads
      n = rd_q.size();
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_ir", {16'd0, instr_ir}, 32'h1234);
         chk("bp_pc", {20'd0, instr_pc}, 32'h002);
      end
      chk("bp_no_reads", rd_q.size(), n);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("bp_rel_rd", {31'd0, mem_read}, 32'd1);
      chk("bp_rel_addr", {20'd0, mem_addr}, 32'h002);

      // I/O word: I=1 but no indirect read
      exp_issue("io", 16'hF400, 12'h400, 2'b10, 12'h003, 3);
      chk("io_reads", rd_q.size(), 3);
      retire_halt();

      // Indirect memory-reference word
      mem[12'h010] = 16'h90AA;
      mem[12'h0AA] = 16'h0123;
      fetch_at(12'h010);
      exp_issue("ind", 16'h90AA, IND ? 12'h123 : 12'h0AA, 2'b00, 12'h011, IND ? 5 : 3);
      chk("ind_nreads", rd_q.size(), IND ? 2 : 1);
      chk("ind_last_rd", {20'd0, rd_q[rd_q.size()-1]}, IND ? 32'h0AA : 32'h010);
      retire_halt();

      // Redirect during F_WT: fetched word discarded
      mem[12'h020] = 16'h1111;
      mem[12'h005] = 16'h2345;
      fetch_at(12'h020);
      tick();
      chk("rdw_wt_rd", {31'd0, mem_read}, 32'd0);
      redir_valid = 1'b1;
      redir_pc    = 12'h005;
      tick();
      redir_valid = 1'b0;
      chk("rdw_rd", {31'd0, mem_read}, 32'd1);
      chk("rdw_addr", {20'd0, mem_addr}, 32'h005);
      exp_issue("rdw", 16'h2345, 12'h345, 2'b00, 12'h006, 3);
      retire_halt();

      // Redirect while the read pulse is out: the retry goes to the new PC
      mem[12'h050] = 16'h6050;
      mem[12'h060] = 16'h6060;
      fetch_at(12'h050);
      redir_valid = 1'b1;
      redir_pc    = 12'h060;
      tick();
      redir_valid = 1'b0;
      n = 0;
      while (!mem_read && n < 4) begin
         tick();
         n++;
      end
      chk("rdr_rd", {31'd0, mem_read}, 32'd1);
      chk("rdr_addr", {20'd0, mem_addr}, 32'h060);
      exp_issue("rdr", 16'h6060, 12'h060, 2'b00, 12'h061, 3);
      retire_halt();

      // PC wrap at the top of memory
      mem[12'hFFF] = 16'h3ABC;
      fetch_at(12'hFFF);
      exp_issue("wrap", 16'h3ABC, 12'hABC, 2'b00, 12'h000, 3);
      retire_halt();

      // Redirect together with the handshake in ISSUE
      mem[12'h030] = 16'h4030;
      mem[12'h040] = 16'h5040;
      fetch_at(12'h030);
      exp_issue("ri1", 16'h4030, 12'h030, 2'b00, 12'h031, 3);
      instr_ready = 1'b1;
      halt        = 1'b0;
      redir_valid = 1'b1;
      redir_pc    = 12'h040;
      tick();
      redir_valid = 1'b0;
      instr_ready = 1'b0;
      chk("ri_valid", {31'd0, instr_valid}, 32'd0);
      chk("ri_rd", {31'd0, mem_read}, 32'd1);
      chk("ri_addr", {20'd0, mem_addr}, 32'h040);
      exp_issue("ri2", 16'h5040, 12'h040, 2'b00, 12'h041, 3);
      retire_halt();

      // Random memory, sequential fetch stream with random backpressure
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      pc = 12'h100 + 12'($urandom_range(0, 255));
      fetch_at(pc);
      for (int i = 0; i < 40; i++) begin
         model(pc, w, ea, cls, ind);
         exp_issue("rnd", w, ea, cls, pc + 12'd1, ind ? 5 : 3);
         chk("rnd_nreads", rd_q.size(), ind ? 2 : 1);
         chk("rnd_last_rd", {20'd0, rd_q[rd_q.size()-1]}, {20'd0, (ind ? w[11:0] : pc)});
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) begin
            tick();
            chk("rnd_hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("rnd_hold_ir", {16'd0, instr_ir}, {16'd0, w});
         end
         pc = pc + 12'd1;
         if (i < 39) begin
            rd_q.delete();
            halt        = 1'b0;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            chk("rnd_next_rd", {31'd0, mem_read}, 32'd1);
            chk("rnd_next_addr", {20'd0, mem_addr}, {20'd0, pc});
         end else begin
            retire_halt();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
